// File: rtl/iic_pkg.sv
// Shared IIC definitions: address width and the target-side protocol state set,
// common to the IIC master and the register target.
package iic_pkg;

    localparam int IIC_ADDR_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } iic_state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       we;
    } iic_reg_req_t;

endpackage

// File: rtl/iic_line_filter.sv
// One bus line: 2-flop synchroniser, FILTER_LEN-sample majority-free glitch filter,
// and single-cycle rise/fall pulses of the filtered level.
module iic_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0]            r_sync;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_level;
    logic                  r_prev;
    logic [FILTER_LEN:0]   w_taps;

    assign w_taps = {r_hist, r_sync[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '1;
            r_hist  <= '1;
            r_level <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_hist <= w_taps[FILTER_LEN-1:0];
            // Level only moves once every sample in the window agrees.
            if (&r_hist)
                r_level <= 1'b1;
            else if (~|r_hist)
                r_level <= 1'b0;
            r_prev <= r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_level & ~r_prev;
    assign o_fall  = ~r_level & r_prev;

endmodule

// File: rtl/iic_slave_reg.sv
// IIC register target: 7-bit address, first written byte sets the register
// pointer, later bytes write with auto-increment; reads stream from the pointer.
module iic_slave_reg
    import iic_pkg::*;
#(
    parameter logic [IIC_ADDR_W-1:0] SLAVE_ADDR = 7'h50,
    parameter int                    FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;

    iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk     (clk),
        .rst     (rst),
        .i_line  (scl_i),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk     (clk),
        .rst     (rst),
        .i_line  (sda_i),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    iic_state_e   r_state, w_state_nxt;
    logic [3:0]   r_bitcnt, w_bitcnt_nxt;
    logic [7:0]   r_shift, w_shift_nxt;
    logic         r_oe, w_oe_nxt;
    logic         r_busy, w_busy_nxt;
    logic         r_first, w_first_nxt;
    logic         r_rw, w_rw_nxt;
    iic_reg_req_t r_req, w_req_nxt;
    // Read fetch pipe: [0] request, [1] reg_re strobe, [2] reg_rdata capture.
    logic [2:0]   r_rd_pipe, w_rd_pipe_nxt;

    logic       w_start, w_stop;
    logic [7:0] w_byte;

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;
    assign w_byte  = {r_shift[6:0], w_sda};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_first   <= 1'b0;
            r_rw      <= 1'b0;
            r_req     <= '0;
            r_rd_pipe <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_shift   <= w_shift_nxt;
            r_oe      <= w_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_first   <= w_first_nxt;
            r_rw      <= w_rw_nxt;
            r_req     <= w_req_nxt;
            r_rd_pipe <= w_rd_pipe_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bitcnt_nxt  = r_bitcnt;
        w_shift_nxt   = r_shift;
        w_oe_nxt      = r_oe;
        w_busy_nxt    = r_busy;
        w_first_nxt   = r_first;
        w_rw_nxt      = r_rw;
        w_req_nxt     = r_req;
        w_req_nxt.we  = 1'b0;
        w_rd_pipe_nxt = {r_rd_pipe[1:0], 1'b0};
        if (r_req.we)
            w_req_nxt.addr = r_req.addr + 8'd1;
        if (r_rd_pipe[2])
            w_shift_nxt = reg_rdata;

        if (w_start) begin
            w_state_nxt  = ADDR;
            w_bitcnt_nxt = '0;
            w_oe_nxt     = 1'b0;
            w_busy_nxt   = 1'b1;
        end else if (w_stop) begin
            w_state_nxt = IDLE;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                ADDR: if (w_scl_rise) begin
                    w_shift_nxt  = w_byte;
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd7) begin
                        w_bitcnt_nxt = '0;
                        if (r_shift[6:0] == SLAVE_ADDR) begin
                            w_state_nxt = ADDR_ACK;
                            w_rw_nxt    = w_sda;
                            w_first_nxt = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                // bitcnt phases: 0 wait fall to drive ACK, 1 wait 9th rise, 2 wait fall to release.
                ADDR_ACK, WR_ACK: begin
                    if (w_scl_fall && r_bitcnt == 4'd0) begin
                        w_oe_nxt     = 1'b1;
                        w_bitcnt_nxt = 4'd1;
                    end else if (w_scl_rise && r_bitcnt == 4'd1) begin
                        w_bitcnt_nxt = 4'd2;
                        if (r_state == ADDR_ACK && r_rw)
                            w_rd_pipe_nxt[0] = 1'b1;
                    end else if (w_scl_fall && r_bitcnt == 4'd2) begin
                        w_bitcnt_nxt = '0;
                        if (r_state == ADDR_ACK && r_rw) begin
                            w_state_nxt = RD_DATA;
                            w_oe_nxt    = ~r_shift[7];
                        end else begin
                            w_state_nxt = WR_DATA;
                            w_oe_nxt    = 1'b0;
                        end
                    end
                end
                WR_DATA: if (w_scl_rise) begin
                    w_shift_nxt  = w_byte;
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd7) begin
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = WR_ACK;
                        if (r_first) begin
                            w_req_nxt.addr = w_byte;
                            w_first_nxt    = 1'b0;
                        end else begin
                            w_req_nxt.wdata = w_byte;
                            w_req_nxt.we    = 1'b1;
                        end
                    end
                end
                RD_DATA: begin
                    if (w_scl_rise)
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    else if (w_scl_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            w_bitcnt_nxt = '0;
                            w_oe_nxt     = 1'b0;
                            w_state_nxt  = RD_ACK;
                        end else begin
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_oe_nxt    = ~r_shift[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (w_scl_rise && r_bitcnt == 4'd0) begin
                        if (!w_sda) begin
                            w_req_nxt.addr   = r_req.addr + 8'd1;
                            w_rd_pipe_nxt[0] = 1'b1;
                            w_bitcnt_nxt     = 4'd1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else if (w_scl_fall && r_bitcnt == 4'd1) begin
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = RD_DATA;
                        w_oe_nxt     = ~r_shift[7];
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_o     = 1'b0;
    assign sda_oe    = r_oe;
    assign reg_addr  = r_req.addr;
    assign reg_wdata = r_req.wdata;
    assign reg_we    = r_req.we;
    assign reg_re    = r_rd_pipe[1];
    assign busy      = r_busy;

endmodule

// File: tb/tb_iic_slave_reg.sv
// Bench for iic_slave_reg: bit-banged bus master, open-drain SDA model,
// register file model returning mem[k]=k.
module tb_iic_slave_reg;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_i, sda_i, sda_o, sda_oe, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata;
    logic [7:0] reg_rdata = 8'h00;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign scl_i = m_scl;
    assign sda_i = m_sda & ~sda_oe;

    iic_slave_reg #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_o     (sda_o),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t we_q[$];
    int  re_cnt = 0;

    always @(negedge clk) begin
        if (reg_we) we_q.push_back({reg_addr, reg_wdata});
        if (reg_re) re_cnt++;
    end

    always @(posedge clk)
        if (reg_re) reg_rdata <= reg_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda = b;  wq();
        m_scl = 1'b1; wq();
        s = sda_i;  wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic start_c();
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b0; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic stop_c();
        m_sda = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b1; wq();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(nack, s);
    endtask

    typedef struct {
        logic [7:0] ab, p, d0, d1;
        logic       ack;
        int         nwe;
        logic [7:0] a0, a1;
    } vec_t;

    initial begin
        vec_t       vt[4];
        logic       ak[4];
        logic       a;
        logic [7:0] d;
        int         re0;

        vt[0] = '{8'hA0, 8'h10, 8'h55, 8'h66, 1'b1, 2, 8'h10, 8'h11};
        vt[1] = '{8'hA0, 8'hFF, 8'h01, 8'h02, 1'b1, 2, 8'hFF, 8'h00};
        vt[2] = '{8'hA2, 8'h10, 8'h55, 8'h66, 1'b0, 0, 8'h00, 8'h00};
        vt[3] = '{8'hA0, 8'h3C, 8'hC3, 8'h5A, 1'b1, 2, 8'h3C, 8'h3D};

        repeat (5) @(posedge clk);
        #1;
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_sda_o", sda_o, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_reg_re", reg_re, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        wq();

        for (int v = 0; v < 4; v++) begin
            we_q.delete();
            re0 = re_cnt;
            start_c();
            wr_byte(vt[v].ab, ak[0]);
            wr_byte(vt[v].p,  ak[1]);
            wr_byte(vt[v].d0, ak[2]);
            wr_byte(vt[v].d1, ak[3]);
            stop_c();
            for (int k = 0; k < 4; k++)
                chk($sformatf("v%0d_ack%0d", v, k), ak[k], vt[v].ack);
            chk($sformatf("v%0d_we_cnt", v), we_q.size(), vt[v].nwe);
            if (we_q.size() >= 2) begin
                chk($sformatf("v%0d_we0_addr", v), we_q[0].a, vt[v].a0);
                chk($sformatf("v%0d_we0_data", v), we_q[0].d, vt[v].d0);
                chk($sformatf("v%0d_we1_addr", v), we_q[1].a, vt[v].a1);
                chk($sformatf("v%0d_we1_data", v), we_q[1].d, vt[v].d1);
            end
            chk($sformatf("v%0d_re_cnt", v), re_cnt - re0, 0);
            chk($sformatf("v%0d_busy", v), busy, 0);
        end

        // Read without pointer write continues where the last write left off.
        re0 = re_cnt;
        start_c();
        wr_byte(8'hA1, a);
        chk("cont_addr_ack", a, 1);
        rd_byte(1'b1, d);
        chk("cont_rd_data", d, 8'h3E);
        stop_c();
        chk("cont_re_cnt", re_cnt - re0, 1);

        // Pointer write, repeated START, 3-byte read.
        we_q.delete();
        start_c();
        wr_byte(8'hA0, a); chk("rs_ack_a0", a, 1);
        wr_byte(8'h20, a); chk("rs_ack_ptr", a, 1);
        start_c();
        wr_byte(8'hA1, a); chk("rs_ack_a1", a, 1);
        rd_byte(1'b0, d);  chk("rs_rd0", d, 8'h20);
        rd_byte(1'b0, d);  chk("rs_rd1", d, 8'h21);
        rd_byte(1'b1, d);  chk("rs_rd2", d, 8'h22);
        chk("rs_oe_after_nack", sda_oe, 0);
        chk("rs_line_after_nack", sda_i, 1);
        chk("rs_busy_before_stop", busy, 1);
        stop_c();
        chk("rs_we_cnt", we_q.size(), 0);
        chk("rs_busy_after_stop", busy, 0);

        // STOP after 4 data bits discards the partial byte.
        we_q.delete();
        start_c();
        wr_byte(8'hA0, a); chk("part_ack_a0", a, 1);
        wr_byte(8'h40, a); chk("part_ack_ptr", a, 1);
        clk_bit(1'b1, a); clk_bit(1'b0, a); clk_bit(1'b1, a); clk_bit(1'b0, a);
        stop_c();
        chk("part_we_cnt", we_q.size(), 0);
        chk("part_busy", busy, 0);
        chk("part_reg_addr", reg_addr, 8'h40);

        // 1-cycle SDA glitches with SCL high: not a START, not a STOP.
        m_sda = 1'b0; @(posedge clk); #1; m_sda = 1'b1;
        wq(); wq();
        chk("glitch_no_start", busy, 0);
        start_c();
        m_scl = 1'b1; wq();
        m_sda = 1'b1; @(posedge clk); #1; m_sda = 1'b0;
        wq(); wq();
        chk("glitch_no_stop", busy, 1);
        m_scl = 1'b0; wq();
        stop_c();
        chk("glitch_stop_busy", busy, 0);

        // Reset while driving SDA low in RD_DATA (mem[0x40] has MSB 0).
        start_c();
        wr_byte(8'hA1, a); chk("rr_ack_a1", a, 1);
        chk("rr_oe_driving", sda_oe, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rr_oe_released", sda_oe, 0);
        repeat (3) @(posedge clk); #1;
        chk("rr_reg_addr", reg_addr, 0);
        chk("rr_busy", busy, 0);
        rst = 1'b0;
        wq();
        stop_c();
        we_q.delete();
        start_c();
        wr_byte(8'hA0, a); chk("rr2_ack_a0", a, 1);
        wr_byte(8'h05, a); chk("rr2_ack_ptr", a, 1);
        wr_byte(8'h77, a); chk("rr2_ack_d", a, 1);
        stop_c();
        chk("rr2_we_cnt", we_q.size(), 1);
        if (we_q.size() >= 1) begin
            chk("rr2_we_addr", we_q[0].a, 8'h05);
            chk("rr2_we_data", we_q[0].d, 8'h77);
        end
        chk("rr2_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iic_slave_reg.md
IIC_SLAVE_REG -- requirements
Module: iic_slave_reg

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit target address it answers.
REQ-002 SHALL have parameter FILTER_LEN, default 3, the number of consecutive equal clk samples needed to accept a new SCL/SDA level.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port scl_i, input, 1 bit: SCL pin level.
REQ-006 SHALL have port sda_i, input, 1 bit: SDA pin level.
REQ-007 SHALL have port sda_o, output, 1 bit: constant 0 (open-drain).
REQ-008 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low.
REQ-009 SHALL have port reg_addr, output, 8 bits: register pointer.
REQ-010 SHALL have port reg_wdata, output, 8 bits: write data.
REQ-011 SHALL have port reg_we, output, 1 bit: one-cycle write strobe.
REQ-012 SHALL have port reg_re, output, 1 bit: one-cycle read strobe.
REQ-013 SHALL have port reg_rdata, input, 8 bits: read data, valid on the cycle after reg_re.
REQ-014 SHALL have port busy, output, 1 bit: high from START to STOP.

Function
REQ-015 SHALL synchronise scl_i/sda_i through 2 flops, then a FILTER_LEN-sample glitch filter; all edge detection uses filtered levels.
REQ-016 SHALL detect START as filtered SDA 1->0 while SCL=1, and STOP as SDA 0->1 while SCL=1; START (including repeated START) from any state -> ADDR, bit count cleared, sda_oe=0.
REQ-017 SHALL use states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-018 SHALL shift SDA in MSB-first on each filtered SCL rise, and change sda_oe only on the cycle a filtered SCL fall is detected.
REQ-019 SHALL, in ADDR after 8 bits: addr[7:1]==SLAVE_ADDR -> ADDR_ACK, driving SDA low for the 9th clock; otherwise -> IDLE with no ACK until the next START.
REQ-020 SHALL, after ADDR_ACK: R/W=0 -> WR_DATA; R/W=1 -> assert reg_re, load the shifter from reg_rdata, -> RD_DATA.
REQ-021 SHALL treat the first WR_DATA byte after an address as the register pointer (load reg_addr, no reg_we); every later byte sets reg_wdata with reg_addr and pulses reg_we for one cycle on the 8th SCL rise, then increments reg_addr (wrap 8'hFF->8'h00); each byte is ACKed in WR_ACK.
REQ-022 SHALL, in RD_DATA, drive sda_oe = ~shift[7] from each SCL fall, 8 bits; then release SDA in RD_ACK and sample master ACK on the 9th rise; ACK(0) -> increment reg_addr, pulse reg_re, reload, RD_DATA; NACK(1) -> IDLE.
REQ-023 SHALL, on STOP in any state, release SDA, deassert busy and go to IDLE; a partial byte is discarded with no reg_we.
REQ-024 SHALL keep reg_addr across transactions, so a read without a pointer write continues from the last pointer.
REQ-025 SHALL never drive SCL (no clock stretching).
REQ-026 SHALL assume reg_rdata may change only when reg_re is asserted.

Reset
REQ-027 SHALL, while rst=1, hold state=IDLE, sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, and set synchroniser and filter stages to 1 (bus idle).
REQ-028 SHALL, on reset mid-transfer, release SDA immediately and ignore bus activity until a fresh START.

Structure
REQ-029 SHALL put the state enumeration and an IIC_ADDR_W=7 constant in the shared iic package, used by both the IIC master and this block.
REQ-030 SHALL implement one sub-module iic_line_filter (2-flop sync + FILTER_LEN filter + rise/fall pulses), instantiated once for SCL and once for SDA.

Verification
REQ-031 SHALL cover: write 0xA0,0x10,0x55,0x66,STOP -> reg_we twice: (0x10,0x55), (0x11,0x66); ACK on all 4 bytes.
REQ-032 SHALL cover: write 0xA0,0x20; repeated START; 0xA1; read 3 bytes (ACK,ACK,NACK), with model mem[k]=k -> bus bytes 0x20,0x21,0x22; SDA released after NACK.
REQ-033 SHALL cover: address 0xA2 -> no ACK (SDA high on 9th clock), no reg_we/reg_re, state IDLE until next START.
REQ-034 SHALL cover: pointer 0xFF, write 0x01,0x02 -> reg_we at 0xFF then 0x00.
REQ-035 SHALL cover: STOP after 4 data bits -> no reg_we, busy=0; a 1-cycle SDA glitch with SCL high -> no START/STOP detected.
REQ-036 SHALL cover: rst asserted while driving SDA low in RD_DATA -> sda_oe=0 the next cycle; the following transaction completes normally.
